// File: rtl/timer_arb_pkg.sv
// Shared types and default constants for the timer arbiter slice.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    WAIT
  } state_t;

  localparam int TICK_DEFAULT = 1000;
  localparam int DW_DEFAULT   = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set req bit after last wins.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic [NREQ-1:0]         onehot
);

  localparam int IW = $clog2(NREQ);

  int cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    // Scan farthest-to-nearest so the nearest requester overwrites the rest.
    for (int i = NREQ; i >= 1; i--) begin
      cand = (int'(last) + i) % NREQ;
      if (req[cand]) begin
        valid  = 1'b1;
        idx    = IW'(cand);
        onehot = NREQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one prescaled delay timer among NREQ requesters.
// Optional abort port enabled by defining TIMER_ARB_CANCEL_EN.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT,
  parameter int TICK = TICK_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] delay,
  input  logic [NREQ-1:0]    ack,
`ifdef TIMER_ARB_CANCEL_EN
  input  logic [NREQ-1:0]    cancel,
`endif
  output logic [NREQ-1:0]    grant,
  output logic               counting,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      remaining
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TICK);

  state_t          state, state_n;
  logic [IW-1:0]   owner, last_grant;
  logic [DW-1:0]   dly_q, rem_q;
  logic [TW-1:0]   tick_q;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] owner_oh;
  logic            tick_end;
  logic            cancel_hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx),
    .onehot(pick_oh)
  );

  assign owner_oh = NREQ'(1) << owner;
  assign tick_end = (tick_q == TW'(TICK - 1));

`ifdef TIMER_ARB_CANCEL_EN
  assign cancel_hit = cancel[owner];
`else
  assign cancel_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_valid) state_n = LOAD;
      LOAD:    state_n = cancel_hit ? IDLE : COUNT;
      COUNT: begin
        if (cancel_hit)                          state_n = IDLE;
        else if (tick_end && rem_q == '0)        state_n = WAIT;
      end
      WAIT:    if (ack[owner]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment to avoid simulation races.
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Owner capture, pointer update and the two counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= '0;
      last_grant <= IW'(NREQ - 1);
      dly_q      <= '0;
      rem_q      <= '0;
      tick_q     <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          owner      <= pick_idx;
          last_grant <= pick_idx;
          dly_q      <= delay[pick_idx*DW +: DW];
        end
        LOAD: begin
          tick_q <= '0;
          rem_q  <= dly_q;
        end
        COUNT: begin
          if (tick_end) begin
            tick_q <= '0;
            if (rem_q != '0) rem_q <= rem_q - 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant     = (state != IDLE) ? owner_oh : '0;
  assign done      = (state == WAIT) ? owner_oh : '0;
  assign counting  = (state == COUNT);
  assign remaining = counting ? rem_q : '0;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter with TICK=4, NREQ=4, DW=4.
module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int TICK = 4;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  delay;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     cancel;
  logic [NREQ-1:0]     grant;
  logic                counting;
  logic [NREQ-1:0]     done;
  logic [DW-1:0]       remaining;

  int checks   = 0;
  int failures = 0;

  timer_arbiter #(.NREQ(NREQ), .DW(DW), .TICK(TICK)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .delay    (delay),
    .ack      (ack),
`ifdef TIMER_ARB_CANCEL_EN
    .cancel   (cancel),
`endif
    .grant    (grant),
    .counting (counting),
    .done     (done),
    .remaining(remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    ack    = '0;
    cancel = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Block is in IDLE with req[g] pending: next cycle must be LOAD for g.
  task automatic start(input int g);
    cyc();
    check($sformatf("load_grant_%0d", g), 32'(grant), 32'(1 << g));
    check($sformatf("load_counting_%0d", g), 32'(counting), 32'd0);
  endtask

  // From LOAD: run the count, hold WAIT extra cycles, then ack and land in IDLE.
  task automatic finish(input int g, input int d, input int extra);
    for (int k = 0; k < (d + 1) * TICK; k++) begin
      cyc();
      check($sformatf("count_%0d_%0d", g, k), 32'(counting), 32'd1);
      check($sformatf("rem_%0d_%0d", g, k), 32'(remaining), 32'(d - k / TICK));
    end
    cyc();
    check($sformatf("wait_done_%0d", g), 32'(done), 32'(1 << g));
    check($sformatf("wait_counting_%0d", g), 32'(counting), 32'd0);
    check($sformatf("wait_rem_%0d", g), 32'(remaining), 32'd0);
    for (int e = 0; e < extra; e++) begin
      cyc();
      check($sformatf("wait_hold_%0d_%0d", g, e), 32'(done), 32'(1 << g));
    end
    ack = NREQ'(1 << g);
    cyc();
    ack = '0;
    check($sformatf("idle_grant_%0d", g), 32'(grant), 32'd0);
    check($sformatf("idle_done_%0d", g), 32'(done), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    delay  = '0;
    ack    = '0;
    cancel = '0;

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_counting", 32'(counting), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);

    // Single request, delay 2: COUNT 2..13, WAIT 14..16, IDLE 17
    req = 4'b0001;
    delay[0*DW +: DW] = 4'd2;
    start(0);
    req = '0;
    finish(0, 2, 2);

    // Simultaneous requests after reset: order 0,1,2,3 with one IDLE cycle each
    do_reset();
    delay = '0;
    req = 4'b1111;
    for (int g = 0; g < NREQ; g++) begin
      start(g);
      req[g] = 1'b0;
      finish(g, 0, 0);
    end

    // Fairness: req0 held, req2 arrives during req0's count
    do_reset();
    delay = '0;
    delay[0*DW +: DW] = 4'd1;
    req = 4'b0001;
    start(0);
    cyc();
    check("fair_counting", 32'(counting), 32'd1);
    req = 4'b0101;
    for (int k = 1; k < 2 * TICK; k++) cyc();
    cyc();
    check("fair_done0", 32'(done), 32'b0001);
    ack = 4'b0001;
    cyc();
    ack = '0;
    check("fair_idle", 32'(grant), 32'd0);
    start(2);
    req[2] = 1'b0;
    finish(2, 0, 0);
    start(0);

    // Wrong ack is ignored in WAIT
    do_reset();
    delay = '0;
    req = 4'b0010;
    start(1);
    req = '0;
    for (int k = 0; k < TICK; k++) cyc();
    cyc();
    check("wack_done", 32'(done), 32'b0010);
    ack = 4'b0100;
    cyc();
    check("wack_hold", 32'(done), 32'b0010);
    ack = 4'b0010;
    cyc();
    ack = '0;
    check("wack_idle_grant", 32'(grant), 32'd0);
    check("wack_idle_done", 32'(done), 32'd0);

    // Reset mid-count with remaining=1
    delay = '0;
    delay[0*DW +: DW] = 4'd1;
    req = 4'b0001;
    start(0);
    req = '0;
    cyc();
    cyc();
    check("mid_rem", 32'(remaining), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_grant", 32'(grant), 32'd0);
    check("mid_counting", 32'(counting), 32'd0);
    check("mid_rem0", 32'(remaining), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    req = 4'b1000;
    start(3);
    req = '0;
    finish(3, 0, 0);

    // Pointer back at NREQ-1 after reset: requester 0 beats requester 3
    do_reset();
    delay = '0;
    req = 4'b1001;
    start(0);
    req = 4'b1000;
    finish(0, 0, 0);
    start(3);
    req = '0;
    finish(3, 0, 0);

`ifdef TIMER_ARB_CANCEL_EN
    // Cancel in COUNT returns to IDLE with no done; pending req2 is next
    do_reset();
    delay = '0;
    delay[1*DW +: DW] = 4'd3;
    req = 4'b0110;
    start(1);
    req = 4'b0100;
    cyc();
    check("cxl_counting", 32'(counting), 32'd1);
    cancel = 4'b0010;
    cyc();
    cancel = '0;
    check("cxl_grant", 32'(grant), 32'd0);
    check("cxl_done", 32'(done), 32'd0);
    start(2);
    req = '0;
    finish(2, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
